// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: operating modes and pulse counter width.
package scan_decoder_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LATCH = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_SCAN  = 2'b11
  } mode_e;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Generic combinational one-hot decoder with enable; all-zero when disabled.
module onehot_dec #(
  parameter int unsigned SEL_W = 4
) (
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [(2**SEL_W)-1:0] o_out
);

  always_comb begin
    o_out = '0;
    if (i_en) o_out[i_sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Mode-driven index register feeding a registered one-hot output (latch, timed pulse, scan).
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  step,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int unsigned N = 2**SEL_W;

  mode_e             w_mode;
  logic [SEL_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_wrap, w_wrap_nxt;
  logic              r_latch, w_latch_nxt;
  logic              w_active_nxt;
  logic [N-1:0]      r_out, w_dec;

  assign w_mode = mode_e'(mode);

  // Next-state logic; the output decode uses next-state values so out moves with idx.
  always_comb begin
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = '0;
    w_busy_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_latch_nxt  = 1'b0;
    w_active_nxt = 1'b0;
    if (load) w_idx_nxt = sel;
    unique case (w_mode)
      MODE_OFF: begin
      end
      MODE_LATCH: begin
        w_latch_nxt  = load | r_latch;
        w_active_nxt = w_latch_nxt;
      end
      MODE_PULSE: begin
        if (load) begin
          w_cnt_nxt  = CNT_W'(PULSE_LEN);
          w_busy_nxt = 1'b1;
        end else if (r_busy) begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_busy_nxt = (w_cnt_nxt != '0);
        end
        w_active_nxt = w_busy_nxt;
      end
      MODE_SCAN: begin
        w_active_nxt = 1'b1;
        // load has priority over step, so a load never produces a wrap pulse
        if (!load && step) begin
          w_idx_nxt  = r_idx + SEL_W'(1);
          w_wrap_nxt = (r_idx == '1);
        end
      end
      default: begin
      end
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_en  (w_active_nxt & en),
    .i_sel (w_idx_nxt),
    .o_out (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_latch <= 1'b0;
      r_out   <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_wrap  <= w_wrap_nxt;
      r_latch <= w_latch_nxt;
      r_out   <= w_dec;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign busy = r_busy;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: main instance SEL_W=4, plus SEL_W=2 and 6 for the decode sweep.
module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst, en, load, step;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic [1:0]  sel2;
  logic [5:0]  sel6;

  logic [15:0] out;
  logic [3:0]  idx;
  logic        busy, wrap;
  logic [3:0]  out2;
  logic [1:0]  idx2;
  logic        busy2, wrap2;
  logic [63:0] out6;
  logic [5:0]  idx6;
  logic        busy6, wrap6;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(4), .PULSE_LEN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel), .step(step),
    .out(out), .idx(idx), .busy(busy), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(2), .PULSE_LEN(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel2), .step(step),
    .out(out2), .idx(idx2), .busy(busy2), .wrap(wrap2)
  );

  scan_decoder #(.SEL_W(6), .PULSE_LEN(4)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel6), .step(step),
    .out(out6), .idx(idx6), .busy(busy6), .wrap(wrap6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [15:0] e_out, input logic [3:0] e_idx,
                            input logic e_busy, input logic e_wrap);
    check({tag, ".out"},  64'(out),  64'(e_out));
    check({tag, ".idx"},  64'(idx),  64'(e_idx));
    check({tag, ".busy"}, 64'(busy), 64'(e_busy));
    check({tag, ".wrap"}, 64'(wrap), 64'(e_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; sel = '0; sel2 = '0; sel6 = '0; step = 1'b0;
    tick(); tick();
    check_main("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    check("reset.out2", 64'(out2), 64'd0);
    check("reset.out6", out6, 64'd0);
    rst = 1'b0;

    // LATCH: load 9, hold, mask with en, unmask
    mode = 2'b01; en = 1'b1; load = 1'b1; sel = 4'd9;
    tick(); check_main("latch_load", 16'h0200, 4'd9, 1'b0, 1'b0);
    load = 1'b0;
    tick(); check_main("latch_hold", 16'h0200, 4'd9, 1'b0, 1'b0);
    en = 1'b0;
    tick(); check_main("latch_en0", 16'h0000, 4'd9, 1'b0, 1'b0);
    en = 1'b1;
    tick(); check_main("latch_en1", 16'h0200, 4'd9, 1'b0, 1'b0);

    // OFF: inactive, load still captures, step ignored
    mode = 2'b00;
    tick(); check_main("off", 16'h0000, 4'd9, 1'b0, 1'b0);
    load = 1'b1; sel = 4'd7;
    tick(); check_main("off_load", 16'h0000, 4'd7, 1'b0, 1'b0);
    load = 1'b0; step = 1'b1;
    tick(); check_main("off_step", 16'h0000, 4'd7, 1'b0, 1'b0);
    step = 1'b0;

    // PULSE: sel=3 high for exactly 4 cycles
    mode = 2'b10; load = 1'b1; sel = 4'd3;
    tick(); check_main("pulse_c1", 16'h0008, 4'd3, 1'b1, 1'b0);
    load = 1'b0;
    tick(); check_main("pulse_c2", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick(); check_main("pulse_c3", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick(); check_main("pulse_c4", 16'h0008, 4'd3, 1'b1, 1'b0);
    tick(); check_main("pulse_end", 16'h0000, 4'd3, 1'b0, 1'b0);

    // PULSE restart: sel=3 then sel=5 two cycles later
    load = 1'b1; sel = 4'd3;
    tick(); check_main("rst_a1", 16'h0008, 4'd3, 1'b1, 1'b0);
    load = 1'b0;
    tick(); check_main("rst_a2", 16'h0008, 4'd3, 1'b1, 1'b0);
    load = 1'b1; sel = 4'd5;
    tick(); check_main("rst_b1", 16'h0020, 4'd5, 1'b1, 1'b0);
    load = 1'b0;
    tick(); check_main("rst_b2", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick(); check_main("rst_b3", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick(); check_main("rst_b4", 16'h0020, 4'd5, 1'b1, 1'b0);
    tick(); check_main("rst_end", 16'h0000, 4'd5, 1'b0, 1'b0);

    // PULSE with en=0 keeps counting
    en = 1'b0; load = 1'b1; sel = 4'd2;
    tick(); check_main("pen_c1", 16'h0000, 4'd2, 1'b1, 1'b0);
    load = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick(); check_main("pen_c4", 16'h0004, 4'd2, 1'b1, 1'b0);
    tick(); check_main("pen_end", 16'h0000, 4'd2, 1'b0, 1'b0);

    // leaving PULSE aborts the pulse
    load = 1'b1; sel = 4'd1;
    tick(); check_main("abort_c1", 16'h0002, 4'd1, 1'b1, 1'b0);
    load = 1'b0; mode = 2'b01;
    tick(); check_main("abort", 16'h0000, 4'd1, 1'b0, 1'b0);

    // SCAN: 14,15,0,1 with wrap at 0; load beats step
    mode = 2'b11; load = 1'b1; sel = 4'd14;
    tick(); check_main("scan_14", 16'h4000, 4'd14, 1'b0, 1'b0);
    load = 1'b0; step = 1'b1;
    tick(); check_main("scan_15", 16'h8000, 4'd15, 1'b0, 1'b0);
    tick(); check_main("scan_0", 16'h0001, 4'd0, 1'b0, 1'b1);
    tick(); check_main("scan_1", 16'h0002, 4'd1, 1'b0, 1'b0);
    load = 1'b1; sel = 4'd15;
    tick(); check_main("scan_ld15", 16'h8000, 4'd15, 1'b0, 1'b0);
    sel = 4'd6;
    tick(); check_main("scan_ld_wins", 16'h0040, 4'd6, 1'b0, 1'b0);

    // reset mid-scan with load and step asserted
    sel = 4'd9; rst = 1'b1;
    tick(); check_main("rst_scan", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0; step = 1'b0;

    // reset mid-pulse
    mode = 2'b10; load = 1'b1; sel = 4'd5;
    tick(); check_main("rp_c1", 16'h0020, 4'd5, 1'b1, 1'b0);
    load = 1'b0; rst = 1'b1;
    tick(); check_main("rst_pulse", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // exhaustive LATCH decode sweep across widths
    mode = 2'b01; en = 1'b1; load = 1'b1;
    for (int s = 0; s < 64; s++) begin
      sel6 = 6'(s); sel = 4'(s); sel2 = 2'(s);
      tick();
      check($sformatf("sw6_%0d", s), out6, 64'd1 << s);
      check($sformatf("sw6i_%0d", s), 64'(idx6), 64'(s));
      if (s < 16) check($sformatf("sw4_%0d", s), 64'(out), 64'd1 << s);
      if (s < 4) check($sformatf("sw2_%0d", s), 64'(out2), 64'd1 << s);
    end
    load = 1'b0;
    check("sw_busy_wrap", {60'd0, busy2, wrap2, busy6, wrap6}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
